// File: rtl/if_fetch_queue.sv
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Circular PC/instruction queue between the fetch and decode stages,
//            with flush and an optional pass-through path (IFQ_BYPASS_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [AW-1:0]            in_pc,
  input  logic [DW-1:0]            in_inst,
  output logic                     in_ready,
  output logic                     stall_req,
  output logic                     out_valid,
  output logic [AW-1:0]            out_pc,
  output logic [DW-1:0]            out_inst,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

  logic [AW-1:0]   r_mem_pc   [DEPTH];
  logic [DW-1:0]   r_mem_inst [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  logic w_empty;
  logic w_byp;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);

`ifdef IFQ_BYPASS_EN
  // Gated by rst so the outputs stay quiet while reset is held.
  assign w_byp = rst & w_empty & in_valid & ~flush;
`else
  assign w_byp = 1'b0;
`endif

  assign in_ready  = (r_count != c_FULL);
  assign stall_req = ~in_ready;
  assign out_valid = ~w_empty | w_byp;
  assign out_pc    = w_byp ? in_pc   : (w_empty ? '0 : r_mem_pc[r_rd_ptr]);
  assign out_inst  = w_byp ? in_inst : (w_empty ? '0 : r_mem_inst[r_rd_ptr]);
  assign count     = r_count;

  // A bypassed pair that decode takes immediately never enters storage.
  assign w_push = in_valid & in_ready & ~flush & ~(w_byp & out_ready);
  assign w_pop  = ~w_empty & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_inst[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]   <= in_pc;
        r_mem_inst[r_wr_ptr] <= in_inst;
        r_wr_ptr             <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 Parameter AW, default 32, instruction address width.
REQ-003 Parameter DW, default 32, instruction word width.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset; rst=0 resets all state immediately, independent of clk.
REQ-006 Port in_valid  input  1  fetch stage presents a PC/instruction pair.
REQ-007 Port in_pc  input  AW  address of the fetched instruction.
REQ-008 Port in_inst  input  DW  instruction word returned by instruction memory.
REQ-009 Port in_ready  output  1  queue can accept a push this cycle.
REQ-010 Port stall_req  output  1  request to the PC stage to hold; always equals ~in_ready.
REQ-011 Port out_valid  output  1  head entry is valid for the decode stage.
REQ-012 Port out_pc  output  AW  PC of the head entry.
REQ-013 Port out_inst  output  DW  instruction of the head entry.
REQ-014 Port out_ready  input  1  decode stage consumes the head entry this cycle.
REQ-015 Port flush  input  1  discard all queued entries (branch/exception redirect).
REQ-016 Port count  output  log2(DEPTH)+1  number of valid entries held.

Function
REQ-017 Push occurs when in_valid=1, in_ready=1 and flush=0; the pair is written at wr_ptr, and wr_ptr advances by 1, modulo DEPTH.
REQ-018 Pop occurs when out_valid=1, out_ready=1 and flush=0; rd_ptr advances by 1, modulo DEPTH.
REQ-019 in_ready = (count != DEPTH), derived from registered count only; a pop in the same cycle does not enable a push into a full queue.
REQ-020 out_valid = (count != 0), except as extended by REQ-030.
REQ-021 out_pc/out_inst come from the entry at rd_ptr; both are forced to 0 whenever out_valid=0.
REQ-022 Count update rules:
- push only: count+1
- pop only: count-1
- simultaneous push and pop: count unchanged, and both pointers advance
REQ-023 Non-bypass latency: an entry pushed in cycle N is first visible on out_* in cycle N+1.
REQ-024 Entries leave in push order; no reordering, duplication or loss except by flush or reset.
REQ-025 Pointer wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble and no data corruption.
REQ-026 Flush behaviour:
- flush=1 at a clock edge sets count, wr_ptr and rd_ptr to 0.
- flush has priority over any push or pop in the same cycle; that push is discarded and no pop is counted.
- out_valid=0 in the cycle after flush.
- in_valid is still honoured from the cycle after flush.
REQ-027 in_valid with in_ready=0 is ignored; the upstream stage is held by stall_req and re-presents the same pair.

Reset
REQ-028 While rst=0, the following hold:
- count=0, wr_ptr=0, rd_ptr=0 and all storage entries=0
- out_valid=0, out_pc=0, out_inst=0
- in_ready=1, stall_req=0
REQ-029 Reset asserted mid-operation discards all entries immediately. The first push after rst returns high is accepted on the first rising clk edge.

Configuration
REQ-030 Macro IFQ_BYPASS_EN controls a zero-latency pass-through path.
- Defined: when count=0, in_valid=1 and flush=0, the module drives out_valid=1, out_pc=in_pc and out_inst=in_inst combinationally in the same cycle.
- Defined, with out_ready=1 in that same cycle: the pair is consumed and not stored, and count stays 0.
- Defined, with out_ready=0: the pair is pushed normally.
- Not defined: no combinational path exists from in_* to out_*, and REQ-023 latency always applies.

Verification
REQ-031 Fill/drain:
- Stimulus: push PCs 0x00, 0x04, 0x08, 0x0C with out_ready=0.
- Response: count=4, in_ready=0 and stall_req=1; a fifth push at 0x10 is not accepted.
- Then set out_ready=1: outputs 0x00, 0x04, 0x08, 0x0C appear in order, and count returns to 0.
REQ-032 Simultaneous push/pop:
- Stimulus: with count=2, hold in_valid=1 and out_ready=1 for 10 cycles.
- Response: count stays 2, and PCs emerge in order across at least two pointer wraps.
REQ-033 Flush priority:
- Stimulus: with count=3, assert flush=1 together with in_valid=1 (in_pc=0x40) and out_ready=1.
- Response: the next cycle shows count=0, out_valid=0, out_pc=0, and 0x40 is never output.
REQ-034 Async reset:
- Stimulus: with count=2, drop rst to 0 between clock edges.
- Response: count=0 and out_valid=0 before the next edge; after release, a push of 0x100 appears on out_pc one cycle later.
REQ-035 Bypass:
- Stimulus: empty queue, in_valid=1, in_pc=0x20, in_inst=0x3C011234, out_ready=1.
- Response with IFQ_BYPASS_EN: out_valid=1 and out_pc=0x20 in the same cycle, and count remains 0.
- Response without it: out_valid=0 that cycle; out_pc=0x20 in the next cycle, and count=1 until it is popped.
